pipeline_hazard_unit: RTL and testbench
=======================================

# pipeline_hazard_unit

Control block driving the enable and flush inputs of the five-stage pipeline registers (fetch/decode, decode/execute, execute/memory) and the PC. It detects load-use hazards, freezes the pipeline for the second cycle of 32-bit memory transfers, flushes wrong-path instructions on taken branches, and sequences interrupt entry. It also keeps a saturating stall-cycle counter for performance measurement.

## Interface
- INT_CYCLES, default 3: length in cycles of the interrupt entry sequence (legal range 1..15).
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- de_mem_read  in  1  instruction in the decode/execute register is a load.
- de_reg_dst_num  in  4  destination register number of that instruction.
- fd_src_1_used  in  1  decoding instruction reads source 1.
- fd_src_1_num  in  3  source 1 register number (zero-extended to 4 bits for compare).
- fd_src_2_used  in  1  decoding instruction reads source 2.
- fd_src_2_num  in  4  source 2 register number.
- em_mem_2cycle  in  1  memory-stage instruction is a 32-bit push/pop/call/ret in its first memory cycle.
- ex_branch_taken  in  1  execute stage resolved a taken branch this cycle.
- int_req  in  1  level interrupt request.
- pc_en  out  1  PC update enable.
- fd_en, de_en, em_en  out  1 each  pipeline register write enables.
- fd_flush  out  1  load a NOP into the fetch/decode register.
- de_bubble  out  1  load all-zero control signals into the decode/execute register.
- int_ack  out  1  one-cycle pulse on the last interrupt-entry cycle.
- stall_count  out  16  saturating count of cycles in which pc_en = 0.

## Operation
- States: RUN, MEM2, INT.
- Reset value of every output: pc_en = fd_en = de_en = em_en = 0, fd_flush = de_bubble = int_ack = 0, stall_count = 0. The state is RUN and the interrupt counter is 0. These values hold while reset is asserted.
- Load-use hazard (luse) = de_mem_read AND ((fd_src_1_used AND {0, fd_src_1_num} == de_reg_dst_num) OR (fd_src_2_used AND fd_src_2_num == de_reg_dst_num)).
- RUN outputs are combinational from the inputs, in this priority order:
  - em_mem_2cycle: all enables 0, no flush. Next state is MEM2.
  - luse: pc_en = 0, fd_en = 0, de_en = 1, em_en = 1, de_bubble = 1. State stays RUN.
  - ex_branch_taken: all enables 1, fd_flush = 1, de_bubble = 1.
  - int_req: pc_en = 0, all other enables 1, fd_flush = 1. Next state is INT and the counter is loaded with INT_CYCLES - 1.
  - Otherwise: all enables 1, no flush.
- MEM2: all enables 0 for exactly one cycle, then RUN. Inputs are ignored during this cycle. The frozen execute stage re-presents ex_branch_taken and the frozen decode stage re-presents the hazard inputs in the following RUN cycle.
- INT outputs:
  - pc_en = 0, fd_flush = 1, de_en = em_en = 1.
  - The counter decrements each cycle.
  - When the counter is 0: int_ack = 1 and the next state is RUN.
  - int_req is ignored while in INT.
- If INT_CYCLES = 1, RUN moves to INT with counter 0, so int_ack fires on the first INT cycle.
- stall_count increments on each rising edge where pc_en = 0 and reset is deasserted. It saturates at 0xFFFF.

## Timing
- Hazard response has zero latency: the RUN outputs respond combinationally to inputs in the same cycle.
- State transitions and counter updates occur on the rising clk edge.
- Load-use stall lasts exactly 1 cycle. The load advances to memory, so luse deasserts naturally on the next cycle.
- A 32-bit memory op freezes the pipeline for 2 cycles total: the detect cycle in RUN plus the MEM2 cycle.
- Interrupt entry stalls the PC for 1 + INT_CYCLES cycles: the detect cycle plus the INT cycles.
- Reset asserted mid-sequence (MEM2 or INT) immediately forces the reset values asynchronously. No int_ack is issued for the aborted sequence.
- After reset is deasserted, the first clock edge evaluates RUN normally.

## Test plan
- Load-use: de_mem_read = 1, de_reg_dst_num = 3, fd_src_1_used = 1, fd_src_1_num = 3 for 1 cycle -> pc_en = fd_en = 0 and de_bubble = 1 for that cycle; stall_count = 1.
- 32-bit memory op: em_mem_2cycle = 1 for 1 cycle -> all enables 0 for 2 consecutive cycles, then all enables 1; stall_count = 2.
- Simultaneous em_mem_2cycle and ex_branch_taken: freeze first with no flush; in the cycle after MEM2 (branch input still high) -> fd_flush = de_bubble = 1.
- Interrupt with INT_CYCLES = 3: pulse int_req -> pc_en = 0 for 4 cycles, fd_flush = 1 throughout, int_ack high on cycle 4 only.
- Reset on the 2nd INT cycle -> outputs immediately 0 with no int_ack; after release, normal RUN with all enables 1.
- Saturation: force 70000 stall cycles -> stall_count holds at 0xFFFF.

Source files
------------

// File: rtl/pipeline_hazard_unit_if.sv
// rtl/pipeline_hazard_unit_if.sv - hazard inputs and pipeline control outputs of the hazard unit
interface pipeline_hazard_unit_if;
   logic        de_mem_read;
   logic [3:0]  de_reg_dst_num;
   logic        fd_src_1_used;
   logic [2:0]  fd_src_1_num;
   logic        fd_src_2_used;
   logic [3:0]  fd_src_2_num;
   logic        em_mem_2cycle;
   logic        ex_branch_taken;
   logic        int_req;
   logic        pc_en;
   logic        fd_en;
   logic        de_en;
   logic        em_en;
   logic        fd_flush;
   logic        de_bubble;
   logic        int_ack;
   logic [15:0] stall_count;

   modport master (
      output de_mem_read, de_reg_dst_num, fd_src_1_used, fd_src_1_num,
             fd_src_2_used, fd_src_2_num, em_mem_2cycle, ex_branch_taken, int_req,
      input  pc_en, fd_en, de_en, em_en, fd_flush, de_bubble, int_ack, stall_count
   );

   modport slave (
      input  de_mem_read, de_reg_dst_num, fd_src_1_used, fd_src_1_num,
             fd_src_2_used, fd_src_2_num, em_mem_2cycle, ex_branch_taken, int_req,
      output pc_en, fd_en, de_en, em_en, fd_flush, de_bubble, int_ack, stall_count
   );
endinterface

// File: rtl/pipeline_hazard_unit.sv
// rtl/pipeline_hazard_unit.sv - load-use/memory-freeze/branch-flush/interrupt-entry pipeline control
module pipeline_hazard_unit #(
   parameter int INT_CYCLES = 3
) (
   input  logic                    clk,
   input  logic                    reset,
   pipeline_hazard_unit_if.slave   bus
);

   typedef enum logic [1:0] {RUN, MEM2, INT} state_t;

   state_t     state, state_next;
   logic [3:0] int_cnt, int_cnt_next;
   logic       luse;

   assign luse = bus.de_mem_read &
                 ((bus.fd_src_1_used & ({1'b0, bus.fd_src_1_num} == bus.de_reg_dst_num)) |
                  (bus.fd_src_2_used & (bus.fd_src_2_num == bus.de_reg_dst_num)));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= RUN;
         int_cnt         <= 4'd0;
         bus.stall_count <= 16'd0;
      end else begin
         state   <= state_next;
         int_cnt <= int_cnt_next;
         if (!bus.pc_en && bus.stall_count != 16'hFFFF)
            bus.stall_count <= bus.stall_count + 16'd1;
      end
   end

   always_comb begin
      state_next    = state;
      int_cnt_next  = int_cnt;
      bus.pc_en     = 1'b0;
      bus.fd_en     = 1'b0;
      bus.de_en     = 1'b0;
      bus.em_en     = 1'b0;
      bus.fd_flush  = 1'b0;
      bus.de_bubble = 1'b0;
      bus.int_ack   = 1'b0;
      case (state)
         RUN: begin
            if (bus.em_mem_2cycle) begin
               state_next = MEM2;
            end else if (luse) begin
               bus.de_en     = 1'b1;
               bus.em_en     = 1'b1;
               bus.de_bubble = 1'b1;
            end else if (bus.ex_branch_taken) begin
               bus.pc_en     = 1'b1;
               bus.fd_en     = 1'b1;
               bus.de_en     = 1'b1;
               bus.em_en     = 1'b1;
               bus.fd_flush  = 1'b1;
               bus.de_bubble = 1'b1;
            end else if (bus.int_req) begin
               bus.fd_en    = 1'b1;
               bus.de_en    = 1'b1;
               bus.em_en    = 1'b1;
               bus.fd_flush = 1'b1;
               state_next   = INT;
               int_cnt_next = 4'(INT_CYCLES - 1);
            end else begin
               bus.pc_en = 1'b1;
               bus.fd_en = 1'b1;
               bus.de_en = 1'b1;
               bus.em_en = 1'b1;
            end
         end
         MEM2: begin
            state_next = RUN;
         end
         INT: begin
            bus.fd_en    = 1'b1;
            bus.de_en    = 1'b1;
            bus.em_en    = 1'b1;
            bus.fd_flush = 1'b1;
            if (int_cnt == 4'd0) begin
               bus.int_ack = 1'b1;
               state_next  = RUN;
            end else begin
               int_cnt_next = int_cnt - 4'd1;
            end
         end
         default: begin
            state_next   = RUN;
            int_cnt_next = 4'd0;
         end
      endcase
      // Reset forces every control output low at once, including mid-sequence.
      if (reset) begin
         bus.pc_en     = 1'b0;
         bus.fd_en     = 1'b0;
         bus.de_en     = 1'b0;
         bus.em_en     = 1'b0;
         bus.fd_flush  = 1'b0;
         bus.de_bubble = 1'b0;
         bus.int_ack   = 1'b0;
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// tb/tb_pipeline_hazard_unit.sv - randomized and directed bench for pipeline_hazard_unit
module tb_pipeline_hazard_unit;
   localparam int INT_CYCLES = 3;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad = 0;

   pipeline_hazard_unit_if hif ();

   pipeline_hazard_unit #(.INT_CYCLES(INT_CYCLES)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (hif.slave)
   );

   always #5 clk = ~clk;

   logic [6:0] ctl;
   assign ctl = {hif.pc_en, hif.fd_en, hif.de_en, hif.em_en, hif.fd_flush, hif.de_bubble, hif.int_ack};

   // Model: pending second memory cycle, INT cycles still to run, stall total.
   bit m_mem_pending;
   int m_int_left;
   int m_stall;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic bit hazard();
      int dst = hif.de_reg_dst_num;
      bit h1 = hif.fd_src_1_used && (int'(hif.fd_src_1_num) == dst);
      bit h2 = hif.fd_src_2_used && (int'(hif.fd_src_2_num) == dst);
      return hif.de_mem_read && (h1 || h2);
   endfunction

   // Bit order: pc_en fd_en de_en em_en fd_flush de_bubble int_ack
   function automatic void expect_ctl(output logic [6:0] e, output logic [6:0] mask);
      mask = 7'b1111111;
      if (m_mem_pending)
         e = 7'b0000000;
      else if (m_int_left > 0) begin
         mask = 7'b1011111;
         e = {1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, (m_int_left == 1)};
      end else if (hif.em_mem_2cycle)
         e = 7'b0000000;
      else if (hazard())
         e = 7'b0011010;
      else if (hif.ex_branch_taken)
         e = 7'b1111110;
      else if (hif.int_req)
         e = 7'b0111100;
      else
         e = 7'b1111000;
   endfunction

   function automatic void model_edge(input logic [6:0] e);
      if (!e[6]) m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
      if (m_mem_pending)
         m_mem_pending = 0;
      else if (m_int_left > 0)
         m_int_left--;
      else if (hif.em_mem_2cycle)
         m_mem_pending = 1;
      else if (!hazard() && !hif.ex_branch_taken && hif.int_req)
         m_int_left = INT_CYCLES;
   endfunction

   function automatic void model_reset();
      m_mem_pending = 0;
      m_int_left = 0;
      m_stall = 0;
   endfunction

   task automatic clear_inputs();
      hif.de_mem_read = 0; hif.de_reg_dst_num = 0;
      hif.fd_src_1_used = 0; hif.fd_src_1_num = 0;
      hif.fd_src_2_used = 0; hif.fd_src_2_num = 0;
      hif.em_mem_2cycle = 0; hif.ex_branch_taken = 0; hif.int_req = 0;
   endtask

   // Called just after a falling edge with inputs applied; returns at the next falling edge.
   task automatic run_cycle(input string tag);
      logic [6:0] e, mask;
      #1;
      expect_ctl(e, mask);
      check({tag, ".ctl"}, 32'(ctl & mask), 32'(e & mask));
      check({tag, ".cnt"}, 32'(hif.stall_count), 32'(m_stall));
      @(posedge clk);
      model_edge(e);
      @(negedge clk);
   endtask

   int base;

   initial begin
      reset = 1'b1;
      clear_inputs();
      model_reset();
      #3;
      check("reset.ctl", 32'(ctl), 32'd0);
      check("reset.cnt", 32'(hif.stall_count), 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      run_cycle("idle");

      // Load-use on source 1
      hif.de_mem_read = 1; hif.de_reg_dst_num = 3; hif.fd_src_1_used = 1; hif.fd_src_1_num = 3;
      #1;
      check("luse.pc_fd", 32'({hif.pc_en, hif.fd_en, hif.de_bubble}), 32'b001);
      run_cycle("luse");
      clear_inputs();
      run_cycle("luse_after");
      check("luse.stall", 32'(hif.stall_count), 32'd1);

      // 32-bit memory freeze
      base = m_stall;
      hif.em_mem_2cycle = 1;
      run_cycle("mem_detect");
      hif.em_mem_2cycle = 0;
      run_cycle("mem2");
      run_cycle("mem_after");
      check("mem.stall", 32'(hif.stall_count), 32'(base + 2));

      // Freeze and branch together: flush comes after the freeze
      hif.em_mem_2cycle = 1; hif.ex_branch_taken = 1;
      #1;
      check("membr.noflush", 32'({hif.fd_flush, hif.de_bubble}), 32'b00);
      run_cycle("membr_detect");
      hif.em_mem_2cycle = 0;
      run_cycle("membr_mem2");
      #1;
      check("membr.flush", 32'({hif.fd_flush, hif.de_bubble}), 32'b11);
      run_cycle("membr_after");
      clear_inputs();

      // Interrupt entry
      base = m_stall;
      hif.int_req = 1;
      run_cycle("int_detect");
      hif.int_req = 0;
      for (int i = 0; i < INT_CYCLES; i++) begin
         #1;
         check($sformatf("int%0d.ack", i), 32'(hif.int_ack), 32'(i == INT_CYCLES - 1));
         run_cycle($sformatf("int%0d", i));
      end
      run_cycle("int_after");
      check("int.stall", 32'(hif.stall_count), 32'(base + 1 + INT_CYCLES));

      // Reset during the second INT cycle
      hif.int_req = 1;
      run_cycle("rint_detect");
      hif.int_req = 0;
      run_cycle("rint_1");
      #1;
      reset = 1'b1;
      #1;
      check("rint.ctl", 32'(ctl), 32'd0);
      check("rint.cnt", 32'(hif.stall_count), 32'd0);
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      run_cycle("rint_post");
      check("rint.run", 32'(ctl), 32'b1111000);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         hif.de_mem_read = ($urandom_range(0, 1) == 1);
         hif.de_reg_dst_num = 4'($urandom_range(0, 7));
         hif.fd_src_1_used = ($urandom_range(0, 1) == 1);
         hif.fd_src_1_num = 3'($urandom);
         hif.fd_src_2_used = ($urandom_range(0, 1) == 1);
         hif.fd_src_2_num = 4'($urandom_range(0, 9));
         hif.em_mem_2cycle = ($urandom_range(0, 7) == 0);
         hif.ex_branch_taken = ($urandom_range(0, 5) == 0);
         hif.int_req = ($urandom_range(0, 11) == 0);
         run_cycle("rnd");
      end
      clear_inputs();

      // Saturation of the stall counter
      hif.de_mem_read = 1; hif.de_reg_dst_num = 5; hif.fd_src_2_used = 1; hif.fd_src_2_num = 5;
      repeat (70000) @(posedge clk);
      @(negedge clk);
      check("sat.cnt", 32'(hif.stall_count), 32'h0000FFFF);
      @(posedge clk);
      @(negedge clk);
      check("sat.hold", 32'(hif.stall_count), 32'h0000FFFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
